// File: rtl/mega8_regs_pkg.sv
// Register indices and reset constants shared by the Mega-8 register bank.
package mega8_regs_pkg;
  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_SP   = 4'd13;
  localparam logic [3:0] REG_PL   = 4'd14;
  localparam logic [3:0] REG_PH   = 4'd15;
  localparam logic [7:0] SP_RESET_DEFAULT = 8'hFF;
endpackage

// File: rtl/reg8_ld.sv
// 8-bit register with async reset value and enabled load.
module reg8_ld #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/register_bank16x8.sv
// Sixteen 8-bit registers: R0 reads zero, R13 is a bounded stack pointer,
// {R15,R14} is a 16-bit pointer with inc/dec.
module register_bank16x8
  import mega8_regs_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic        ptr_inc,
  input  logic        ptr_dec,
  input  logic        sp_push,
  input  logic        sp_pop,
  output logic [7:0]  r0,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [7:0]  r3,
  output logic [7:0]  r4,
  output logic [7:0]  r5,
  output logic [7:0]  r6,
  output logic [7:0]  r7,
  output logic [7:0]  r8,
  output logic [7:0]  r9,
  output logic [7:0]  r10,
  output logic [7:0]  r11,
  output logic [7:0]  r12,
  output logic [7:0]  r13,
  output logic [7:0]  r14,
  output logic [7:0]  r15,
  output logic [15:0] ptr,
  output logic        sp_empty,
  output logic        sp_full,
  output logic        sp_err
);
  logic [12:1][7:0] gq;
  logic [7:0]       sp_q;
  logic [15:0]      ptr_q;

  genvar i;
  generate
    for (i = 1; i <= 12; i++) begin : g_gpr
      reg8_ld #(.RST_VAL(8'h00)) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (we && (waddr == 4'(i))),
        .d   (wdata),
        .q   (gq[i])
      );
    end
  endgenerate

  logic wr_sp, wr_pl, wr_ph;
  logic push_only, pop_only, inc_only, dec_only;

  assign wr_sp     = we && (waddr == REG_SP);
  assign wr_pl     = we && (waddr == REG_PL);
  assign wr_ph     = we && (waddr == REG_PH);
  assign push_only = sp_push && !sp_pop;
  assign pop_only  = sp_pop && !sp_push;
  assign inc_only  = ptr_inc && !ptr_dec;
  assign dec_only  = ptr_dec && !ptr_inc;

  assign sp_empty = (sp_q == SP_RESET);
  assign sp_full  = (sp_q == 8'h00);

  // A write to either pointer byte wins over the whole 16-bit step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ptr_q <= 16'h0000;
    else if (wr_pl)    ptr_q <= {ptr_q[15:8], wdata};
    else if (wr_ph)    ptr_q <= {wdata, ptr_q[7:0]};
    else if (inc_only) ptr_q <= ptr_q + 16'h0001;
    else if (dec_only) ptr_q <= ptr_q - 16'h0001;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= SP_RESET;
      sp_err <= 1'b0;
    end else begin
      sp_err <= 1'b0;
      if (wr_sp) begin
        sp_q <= wdata;
      end else if (push_only) begin
        if (sp_full) sp_err <= 1'b1;
        else         sp_q   <= sp_q - 8'h01;
      end else if (pop_only) begin
        if (sp_empty) sp_err <= 1'b1;
        else          sp_q   <= sp_q + 8'h01;
      end
    end
  end

  assign r0  = 8'h00;
  assign r1  = gq[1];
  assign r2  = gq[2];
  assign r3  = gq[3];
  assign r4  = gq[4];
  assign r5  = gq[5];
  assign r6  = gq[6];
  assign r7  = gq[7];
  assign r8  = gq[8];
  assign r9  = gq[9];
  assign r10 = gq[10];
  assign r11 = gq[11];
  assign r12 = gq[12];
  assign r13 = sp_q;
  assign r14 = ptr_q[7:0];
  assign r15 = ptr_q[15:8];
  assign ptr = ptr_q;
endmodule

// File: doc/register_bank16x8.md
# register_bank16x8

Sixteen-entry, 8-bit general register bank for the Mega-8 datapath. Its sixteen registered outputs feed `mux16x8` directly, which selects the operand for the ALU or bus. Beyond plain writes, the bank holds three special registers:
- R0 is hardwired to zero.
- R13 is a down-growing stack pointer with push/pop stepping and overflow/underflow detection.
- R15:R14 form a 16-bit memory pointer with carry-propagating increment and decrement.

## Interface
Parameters:
- `SP_RESET`, default 8'hFF: reset value of R13, the empty-stack position.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  write enable for the general write port.
- `waddr`  in  4  write register index.
- `wdata`  in  8  write data.
- `ptr_inc`  in  1  increment the 16-bit pointer {R15,R14}.
- `ptr_dec`  in  1  decrement the 16-bit pointer {R15,R14}.
- `sp_push`  in  1  decrement R13.
- `sp_pop`  in  1  increment R13.
- `r0` … `r15`  out  8 each  current register contents; wire straight to `mux16x8` in0…in15.
- `ptr`  out  16  {R15,R14}.
- `sp_empty`  out  1  combinational; high when R13 == SP_RESET.
- `sp_full`  out  1  combinational; high when R13 == 8'h00.
- `sp_err`  out  1  registered one-cycle pulse on an ignored push or pop.

## Operation
- **Reset (async, immediate):**
  - R0–R12, R14, R15 = 8'h00.
  - R13 = SP_RESET.
  - `sp_err` = 0.
  - Therefore `ptr` = 16'h0000, `sp_empty` = 1, `sp_full` = 0.
- **R0:** writes are ignored and `r0` is always 8'h00.
- **General write:** when `we`=1 and `waddr`≠0, register[waddr] ← wdata.
- **Pointer update:**
  - `ptr_inc` alone: {R15,R14} ← {R15,R14} + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000.
  - `ptr_dec` alone: {R15,R14} ← {R15,R14} − 1, modulo 2^16. 16'h0000 wraps to 16'hFFFF.
  - `ptr_inc` and `ptr_dec` together: no change.
- **Stack pointer update:**
  - `sp_push` alone with `sp_full`=0: R13 ← R13 − 1.
  - `sp_pop` alone with `sp_empty`=0: R13 ← R13 + 1.
  - `sp_push` alone with `sp_full`=1: ignored; `sp_err` pulses.
  - `sp_pop` alone with `sp_empty`=1: ignored; `sp_err` pulses.
  - `sp_push` and `sp_pop` together: no change, no error.
- **Priority when a write and a step hit the same register:**
  - Write to R14 or R15 suppresses the whole pointer step that cycle; the written byte lands and the other byte holds.
  - Write to R13 suppresses the push/pop step and error detection that cycle.
  - Steps on non-targeted special registers proceed normally in the same cycle as a write elsewhere.
- **Independence:** pointer and stack-pointer operations may occur in the same cycle and do not interact.

## Timing
- Every register updates on the rising `clk` edge and is visible on its output one cycle after the controlling inputs are sampled.
- No write-to-read bypass: a same-cycle read through `mux16x8` returns the old value.
- `sp_empty` and `sp_full` are decoded combinationally from the registered R13 and follow it with zero added latency.
- `sp_err` is high for exactly the one cycle after the offending edge and is cleared on the following edge unless the error repeats.
- Reset asserted mid-operation clears all state immediately, regardless of `clk`. The first edge after reset deasserts may already perform a write or step.

## Structure
- Shared package `mega8_regs_pkg` holds the fixed register indices and the default stack reset value:
  - `REG_ZERO` = 0
  - `REG_SP` = 13
  - `REG_PL` = 14
  - `REG_PH` = 15
  - `SP_RESET_DEFAULT` = 8'hFF
- One sub-module is natural: `reg8_ld`, an 8-bit register with async reset value, load, and enable.
  - Instantiated for R1–R12.
  - The R13/R14/R15 next-state logic is written in the top level because of its priority and carry rules.

## Test plan
- **Reset and writes:** assert `rst` → all outputs 8'h00 except `r13` = 8'hFF, `sp_empty` = 1. Write 8'h5A to index 0 and 8'hC3 to index 7 → `r0` = 8'h00, `r7` = 8'hC3 one cycle later.
- **Pointer carry and wrap:**
  - Load R15 = 8'h12, R14 = 8'hFF, pulse `ptr_inc` → `ptr` = 16'h1300.
  - Then `ptr_dec` → 16'h12FF.
  - From 16'hFFFF, `ptr_inc` → 16'h0000.
- **Stack bounds:**
  - From reset, `sp_pop` → R13 stays 8'hFF, `sp_err` pulses one cycle.
  - 255 pushes → R13 = 8'h00, `sp_full` = 1.
  - A further push → R13 stays 8'h00, `sp_err` pulses.
- **Write priority:**
  - With `ptr` = 16'h00FF, assert `we`, `waddr` = 14, `wdata` = 8'h10, and `ptr_inc` together → `ptr` = 16'h0010.
  - Write R13 = 8'h40 with `sp_push` → R13 = 8'h40, no `sp_err`.
- **Simultaneous ops:**
  - `ptr_inc` + `ptr_dec` together → `ptr` unchanged.
  - `sp_push` + `sp_pop` together → R13 unchanged, no error.
- **Async reset mid-stream:** during back-to-back writes, assert `rst` between clock edges → outputs return to reset values before the next edge.
